// File: rtl/mem_bus_responder_pkg.sv
// Shared types for the memory bus responder slice.
// Cacheline, request/response bundles and responder FSM states.
package VX_tb_common_pkg;

  localparam int MR_DEFAULT_DEPTH   = 1024;
  localparam int MR_DEFAULT_LATENCY = 4;
  localparam int MR_LINE_BYTES      = 8;
  localparam int MR_ADDR_W          = 32;
  localparam int MR_TAG_W           = 8;

  typedef enum logic {
    MR_INIT,
    MR_ACTIVE
  } memory_responder_state_t;

  typedef logic [MR_LINE_BYTES*8-1:0] risc_v_cacheline_t;

  typedef struct packed {
    logic                     rw;
    logic [MR_ADDR_W-1:0]     addr;
    logic [MR_LINE_BYTES-1:0] byteen;
    risc_v_cacheline_t        data;
    logic [MR_TAG_W-1:0]      tag;
  } mem_req_t;

  typedef struct packed {
    risc_v_cacheline_t   data;
    logic [MR_TAG_W-1:0] tag;
  } mem_rsp_t;

endpackage

// File: rtl/VX_mem_bus_if.sv
// Memory bus: valid/ready request channel and response channel.
// Master issues requests; slave returns read responses.
interface VX_mem_bus_if;
  import VX_tb_common_pkg::*;

  logic     req_valid;
  logic     req_ready;
  mem_req_t req_data;
  logic     rsp_valid;
  logic     rsp_ready;
  mem_rsp_t rsp_data;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/mem_bus_responder_fifo.sv
// Response FIFO: circular buffer with occupancy count.
// Push is ignored when full, pop ignored when empty.
module mem_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory bus responder: cleared backing store, fixed-latency reads,
// credit-controlled response FIFO and access counters.
module mem_bus_responder
  import VX_tb_common_pkg::*;
#(
  parameter int DEPTH          = MR_DEFAULT_DEPTH,
  parameter int RSP_LATENCY    = MR_DEFAULT_LATENCY,
  parameter int RSP_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  VX_mem_bus_if.slave mem_bus_if,
  output logic        init_done,
  output logic [31:0] wr_count,
  output logic [31:0] rd_count,
  output logic [31:0] oob_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RSP_FIFO_DEPTH) + 1;
  localparam int RW = $bits(mem_rsp_t);

  memory_responder_state_t state, state_n;

  risc_v_cacheline_t store [DEPTH];
  logic [AW-1:0]     clr_idx;
  logic              req_ready_q;
  logic [CW-1:0]     credits, credits_n;
  mem_req_t          req;
  mem_rsp_t          rd_rsp;
  logic              acc, wr_acc, rd_acc, oob;
  logic              push, pop, stall;
  logic              full, empty;
  logic [CW-1:0]     fifo_count;
  logic [RW-1:0]     fifo_dout;

  mem_rsp_t                 dl_d [RSP_LATENCY];
  logic [RSP_LATENCY-1:0]   dl_v;

  assign req    = mem_bus_if.req_data;
  assign acc    = mem_bus_if.req_valid && req_ready_q;
  assign wr_acc = acc && req.rw;
  assign rd_acc = acc && !req.rw;
  assign oob    = req.addr >= MR_ADDR_W'(DEPTH);

  always_comb begin
    rd_rsp.tag  = req.tag;
    rd_rsp.data = oob ? '0 : store[req.addr[AW-1:0]];
  end

  // Credits count reads in the delay line plus FIFO entries.
  assign stall = dl_v[RSP_LATENCY-1] && full;
  assign push  = dl_v[RSP_LATENCY-1] && !full;
  assign pop   = !empty && mem_bus_if.rsp_ready;

  always_comb begin
    state_n   = state;
    credits_n = credits + CW'(rd_acc) - CW'(pop);
    unique case (state)
      MR_INIT:   if (clr_idx == AW'(DEPTH - 1)) state_n = MR_ACTIVE;
      MR_ACTIVE: state_n = MR_ACTIVE;
      default:   state_n = MR_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= MR_INIT;
      clr_idx     <= '0;
      credits     <= '0;
      req_ready_q <= 1'b0;
      wr_count    <= '0;
      rd_count    <= '0;
      oob_count   <= '0;
      dl_v        <= '0;
    end else begin
      state       <= state_n;
      credits     <= credits_n;
      req_ready_q <= (state_n == MR_ACTIVE) &&
                     (credits_n < CW'(RSP_FIFO_DEPTH));
      if (state == MR_INIT) clr_idx <= clr_idx + AW'(1);
      if (wr_acc)           wr_count <= wr_count + 32'd1;
      if (rd_acc)           rd_count <= rd_count + 32'd1;
      if (acc && oob)       oob_count <= oob_count + 32'd1;
      if (!stall) begin
        dl_v[0] <= rd_acc;
        for (int i = 1; i < RSP_LATENCY; i++) dl_v[i] <= dl_v[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      dl_d[0] <= rd_rsp;
      for (int i = 1; i < RSP_LATENCY; i++) dl_d[i] <= dl_d[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (state == MR_INIT) begin
      store[clr_idx] <= '0;
    end else if (wr_acc && !oob) begin
      for (int b = 0; b < MR_LINE_BYTES; b++)
        if (req.byteen[b])
          store[req.addr[AW-1:0]][b*8 +: 8] <= req.data[b*8 +: 8];
    end
  end

  mem_rsp_fifo #(
    .WIDTH (RW),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (dl_d[RSP_LATENCY-1]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign init_done            = (state == MR_ACTIVE);
  assign mem_bus_if.req_ready = req_ready_q;
  assign mem_bus_if.rsp_valid = (fifo_count != '0);
  assign mem_bus_if.rsp_data  = mem_rsp_t'(fifo_dout);

endmodule

// File: tb/tb_mem_bus_responder.sv
// Testbench for mem_bus_responder: reference-model scoreboard
// with directed scenarios and randomized traffic.
module tb_mem_bus_responder;
  import VX_tb_common_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT   = 4;
  localparam int FD    = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init_done;
  logic [31:0] wr_count, rd_count, oob_count;

  always #5 clk = ~clk;

  VX_mem_bus_if bus ();

  mem_bus_responder #(
    .DEPTH          (DEPTH),
    .RSP_LATENCY    (LAT),
    .RSP_FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_bus_if (bus),
    .init_done  (init_done),
    .wr_count   (wr_count),
    .rd_count   (rd_count),
    .oob_count  (oob_count)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] model [DEPTH];
  mem_rsp_t    exp_q [$];
  int          n_wr, n_rd, n_oob;
  int          cyc = 0;
  int          last_rd_acc_cyc, last_rsp_cyc;
  mem_rsp_t    last_rsp;
  mem_req_t    mon_req;
  mem_rsp_t    mon_exp;
  bit          rand_rdy = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_q.delete();
    n_wr = 0;
    n_rd = 0;
    n_oob = 0;
  endtask

  // Reference model and response scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (reset && bus.req_valid && bus.req_ready) begin
      mon_req = bus.req_data;
      if (mon_req.addr >= 32'(DEPTH)) n_oob++;
      if (mon_req.rw) begin
        n_wr++;
        if (mon_req.addr < 32'(DEPTH))
          for (int b = 0; b < 8; b++)
            if (mon_req.byteen[b])
              model[mon_req.addr[3:0]][b*8 +: 8] = mon_req.data[b*8 +: 8];
      end else begin
        n_rd++;
        last_rd_acc_cyc = cyc;
        mon_exp.tag  = mon_req.tag;
        mon_exp.data = (mon_req.addr < 32'(DEPTH)) ?
                       model[mon_req.addr[3:0]] : 64'd0;
        exp_q.push_back(mon_exp);
      end
    end
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      last_rsp     = bus.rsp_data;
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {56'd0, bus.rsp_data.tag}, 64'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_data", bus.rsp_data.data, mon_exp.data);
        check("rsp_tag", {56'd0, bus.rsp_data.tag}, {56'd0, mon_exp.tag});
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(bit rw, logic [31:0] addr, logic [7:0] be,
                       logic [63:0] d, logic [7:0] tag);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    bus.req_data = '{rw: rw, addr: addr, byteen: be, data: d, tag: tag};
    bus.req_valid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = bus.req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.req_valid = 1'b0;
    if (!ok) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!init_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("init_wait", {63'd0, init_done}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int rd_base;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("rst_init_done", {63'd0, init_done}, 64'd0);
    check("rst_counters", {wr_count, rd_count | oob_count}, 64'd0);

    // Init sweep: 16 cycles not ready, ready on the 17th.
    @(posedge clk);
    #1;
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (bus.req_ready || init_done) bad++;
    end
    check("init_ready_low", 64'(bad), 64'd0);
    @(negedge clk);
    check("init_done", {63'd0, init_done}, 64'd1);
    check("init_ready", {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk);
    #1;

    issue(0, 32'd5, 8'h00, 64'd0, 8'd1);
    wait_drain();
    check("init_read5", last_rsp.data, 64'd0);

    // Full write then read with latency.
    issue(1, 32'd3, 8'hFF, {8{8'hA5}}, 8'd0);
    issue(0, 32'd3, 8'h00, 64'd0, 8'd7);
    wait_drain();
    check("wr_rd_data", last_rsp.data, {8{8'hA5}});
    check("wr_rd_tag", {56'd0, last_rsp.tag}, 64'd7);
    check("latency", 64'(last_rsp_cyc - last_rd_acc_cyc), 64'(LAT + 1));
    check("wr_count1", {32'd0, wr_count}, 64'd1);
    check("rd_count2", {32'd0, rd_count}, 64'd2);

    // Partial write into a zeroed line.
    issue(1, 32'd4, 8'h01, {8{8'hFF}}, 8'd0);
    issue(0, 32'd4, 8'h00, 64'd0, 8'd2);
    wait_drain();
    check("partial_wr", last_rsp.data, 64'h0000_0000_0000_00FF);

    // Backpressure: only FD reads accepted while responses stall.
    bus.rsp_ready = 1'b0;
    rd_base = n_rd;
    for (int t = 0; t < FD; t++) issue(0, 32'(t), 8'h00, 64'd0, 8'(t));
    bus.req_data  = '{rw: 1'b0, addr: 32'd8, byteen: 8'h00,
                      data: 64'd0, tag: 8'd8};
    bus.req_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("bp_req_ready", {63'd0, bus.req_ready}, 64'd0);
    check("bp_rd_count", {32'd0, rd_count}, 64'(rd_base + FD));
    check("bp_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    issue(0, 32'd8, 8'h00, 64'd0, 8'd8);
    issue(0, 32'd9, 8'h00, 64'd0, 8'd9);
    wait_drain();
    check("bp_last_tag", {56'd0, last_rsp.tag}, 64'd9);

    // Out of range: write dropped, read returns zero.
    issue(1, 32'(DEPTH), 8'hFF, {8{8'h3C}}, 8'd0);
    issue(0, 32'(DEPTH), 8'h00, 64'd0, 8'd9);
    wait_drain();
    check("oob_data", last_rsp.data, 64'd0);
    check("oob_tag", {56'd0, last_rsp.tag}, 64'd9);
    check("oob_count", {32'd0, oob_count}, 64'd2);
    issue(0, 32'd0, 8'h00, 64'd0, 8'd11);
    wait_drain();
    check("oob_no_alias", last_rsp.data, 64'd0);

    // Randomized traffic with random response backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      issue($urandom_range(0, 1) == 1, 32'($urandom_range(0, DEPTH + 2)),
            8'($urandom), {$urandom, $urandom}, 8'($urandom));
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rand_rdy = 0;
    @(posedge clk);
    #2;
    bus.rsp_ready = 1'b1;
    wait_drain();
    check("final_wr_count", {32'd0, wr_count}, 64'(n_wr));
    check("final_rd_count", {32'd0, rd_count}, 64'(n_rd));
    check("final_oob_count", {32'd0, oob_count}, 64'(n_oob));

    // Reset with three reads in the delay line.
    issue(0, 32'd3, 8'h00, 64'd0, 8'd21);
    issue(0, 32'd3, 8'h00, 64'd0, 8'd22);
    issue(0, 32'd3, 8'h00, 64'd0, 8'd23);
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("mid_rst_ready", {63'd0, bus.req_ready}, 64'd0);
    check("mid_rst_counters", {wr_count, rd_count}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_init();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) bad++;
    end
    check("no_stale_rsp", 64'(bad), 64'd0);
    @(posedge clk);
    #1;
    issue(0, 32'd3, 8'h00, 64'd0, 8'd30);
    wait_drain();
    check("post_rst_clear", last_rsp.data, 64'd0);
    check("post_rst_rd_count", {32'd0, rd_count}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
